// File: rtl/i2c_tof_target.sv
// I2C target at SLAVE_ADDR emulating a ToF sensor register map: 16-bit auto-increment pointer, byte memory, host port.
// Latency: SDA_t and strobes update 3 clk after the pin-level SCL edge (2-flop sync + 1 register); host read 1 clk.
// Backpressure: none; never stretches SCL, ACKs every matched byte, and the I2C write wins a same-address host-write collision.
module i2c_tof_target #(
    parameter logic [6:0] SLAVE_ADDR = 7'h29,
    parameter int         MEM_AW     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              SCL_in,
    input  logic              SDA_in,
    output logic              SDA_t,
    input  logic              host_wr_en,
    input  logic [MEM_AW-1:0] host_addr,
    input  logic [7:0]        host_wr_data,
    output logic [7:0]        host_rd_data,
    output logic              wr_strobe,
    output logic [15:0]       wr_addr,
    output logic [7:0]        wr_data,
    output logic              rd_strobe,
    output logic              busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ACK_A, S_PTRH, S_ACK_H, S_PTRL,
        S_ACK_L, S_WDATA, S_ACK_W, S_RDATA, S_MACK, S_IGNORE
    } state_t;

    state_t      state;
    logic        scl_s1, scl_s2, scl_prev;
    logic        sda_s1, sda_s2, sda_prev;
    logic        scl_rise, scl_fall, start_det, stop_det;
    logic [6:0]  shreg;       // first seven bits of the byte being received
    logic [2:0]  bit_cnt;
    logic [7:0]  rx_byte;     // completed byte including the bit on the current SCL rise
    logic        rx_phase;
    logic [7:0]  ptr_hi;
    logic [15:0] ptr;
    logic        rw;
    logic        ph;          // second half of an ACK/MACK slot
    logic        nack;        // master's response sampled in MACK
    logic [6:0]  tx_sh;       // read bits still to be driven after bit 7
    logic        i2c_we;
    logic [7:0]  rd_byte;
    logic [7:0]  mem [0:(1<<MEM_AW)-1];

    assign scl_rise  = scl_s2 & ~scl_prev;
    assign scl_fall  = ~scl_s2 & scl_prev;
    assign start_det = scl_s2 & scl_prev & sda_prev & ~sda_s2;
    assign stop_det  = scl_s2 & scl_prev & ~sda_prev & sda_s2;
    assign rx_byte   = {shreg, sda_s2};
    assign rx_phase  = (state == S_ADDR) || (state == S_PTRH) ||
                       (state == S_PTRL) || (state == S_WDATA);
    assign i2c_we    = (state == S_WDATA) && scl_rise && (bit_cnt == 3'd7);
    assign rd_byte   = mem[ptr[MEM_AW-1:0]];

    // Two-flop synchronizers plus previous-value registers for edge and START/STOP detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_prev <= 1'b1;
            sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_prev <= 1'b1;
        end else begin
            scl_s1 <= SCL_in; scl_s2 <= scl_s1; scl_prev <= scl_s2;
            sda_s1 <= SDA_in; sda_s2 <= sda_s1; sda_prev <= sda_s2;
        end
    end

    // Byte memory: the I2C write takes priority over a host write to the same address
    always_ff @(posedge clk) begin
        if (host_wr_en && !(i2c_we && (host_addr == ptr[MEM_AW-1:0])))
            mem[host_addr] <= host_wr_data;
        if (i2c_we)
            mem[ptr[MEM_AW-1:0]] <= rx_byte;
    end

    // Registered host read port, independent of bus activity
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) host_rd_data <= 8'h00;
        else        host_rd_data <= mem[host_addr];
    end

    // Protocol FSM: START/STOP override everything, bits sampled on SCL rise, SDA changed on SCL fall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            SDA_t     <= 1'b1;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            rd_strobe <= 1'b0;
            wr_addr   <= 16'h0000;
            wr_data   <= 8'h00;
            shreg     <= 7'h00;
            bit_cnt   <= 3'd0;
            ptr_hi    <= 8'h00;
            ptr       <= 16'h0000;
            rw        <= 1'b0;
            ph        <= 1'b0;
            nack      <= 1'b0;
            tx_sh     <= 7'h00;
        end else begin
            wr_strobe <= 1'b0;
            rd_strobe <= 1'b0;
            if (start_det) begin
                state   <= S_ADDR;
                bit_cnt <= 3'd0;
                busy    <= 1'b0;
                SDA_t   <= 1'b1;
                ph      <= 1'b0;
            end else if (stop_det) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                SDA_t <= 1'b1;
                ph    <= 1'b0;
            end else begin
                if (rx_phase && scl_rise) begin
                    shreg   <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                end
                case (state)
                    S_ADDR: if (scl_rise && bit_cnt == 3'd7) begin
                        if (rx_byte[7:1] == SLAVE_ADDR) begin
                            rw    <= rx_byte[0];
                            busy  <= 1'b1;
                            state <= S_ACK_A;
                        end else begin
                            state <= S_IGNORE;
                        end
                    end
                    S_PTRH: if (scl_rise && bit_cnt == 3'd7) begin
                        ptr_hi <= rx_byte;
                        state  <= S_ACK_H;
                    end
                    S_PTRL: if (scl_rise && bit_cnt == 3'd7) begin
                        ptr   <= {ptr_hi, rx_byte};
                        state <= S_ACK_L;
                    end
                    S_WDATA: if (i2c_we) begin
                        wr_strobe <= 1'b1;
                        wr_addr   <= ptr;
                        wr_data   <= rx_byte;
                        ptr       <= ptr + 16'd1;
                        state     <= S_ACK_W;
                    end
                    S_ACK_A: if (scl_fall) begin
                        if (!ph) begin
                            SDA_t <= 1'b0;
                            ph    <= 1'b1;
                        end else begin
                            ph <= 1'b0;
                            if (rw) begin
                                tx_sh     <= rd_byte[6:0];
                                SDA_t     <= rd_byte[7];
                                rd_strobe <= 1'b1;
                                state     <= S_RDATA;
                            end else begin
                                SDA_t <= 1'b1;
                                state <= S_PTRH;
                            end
                        end
                    end
                    S_ACK_H, S_ACK_L, S_ACK_W: if (scl_fall) begin
                        if (!ph) begin
                            SDA_t <= 1'b0;
                            ph    <= 1'b1;
                        end else begin
                            ph    <= 1'b0;
                            SDA_t <= 1'b1;
                            state <= (state == S_ACK_H) ? S_PTRL : S_WDATA;
                        end
                    end
                    S_RDATA: begin
                        if (scl_fall) begin
                            SDA_t <= tx_sh[6];
                            tx_sh <= {tx_sh[5:0], 1'b0};
                        end
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                ptr   <= ptr + 16'd1;
                                state <= S_MACK;
                            end
                        end
                    end
                    S_MACK: begin
                        if (scl_rise) begin
                            nack <= sda_s2;
                            ph   <= 1'b1;
                        end
                        if (scl_fall) begin
                            if (!ph) begin
                                SDA_t <= 1'b1;
                            end else if (!nack) begin
                                ph        <= 1'b0;
                                tx_sh     <= rd_byte[6:0];
                                SDA_t     <= rd_byte[7];
                                rd_strobe <= 1'b1;
                                state     <= S_RDATA;
                            end else begin
                                ph    <= 1'b0;
                                state <= S_IGNORE;
                            end
                        end
                    end
                    S_IDLE, S_IGNORE: ;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_tof_target.sv
// Bench for i2c_tof_target: an I2C master model drives the bus, a reference model predicts writes/reads.
// Expected strobes, read bytes and host reads are queued and checked by a separate monitor process.
`timescale 1ns/1ps
module tb_i2c_tof_target;
    localparam int H = 16;
    localparam int Q = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        scl_m = 1'b1, sda_m = 1'b1;
    logic        scl_line, sda_line;
    logic        SDA_t;
    logic        host_wr_en = 1'b0;
    logic [7:0]  host_addr = 8'h00, host_wr_data = 8'h00;
    logic [7:0]  host_rd_data;
    logic        wr_strobe, rd_strobe, busy;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;

    assign scl_line = scl_m;
    assign sda_line = sda_m & SDA_t;

    i2c_tof_target dut (
        .clk(clk), .reset(reset), .SCL_in(scl_line), .SDA_in(sda_line), .SDA_t(SDA_t),
        .host_wr_en(host_wr_en), .host_addr(host_addr), .host_wr_data(host_wr_data),
        .host_rd_data(host_rd_data), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_strobe(rd_strobe), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0, passed = 0;
    int rd_cnt = 0, exp_rd_cnt = 0;
    logic [7:0]  mem_m [256];
    logic [15:0] ptr_m = 16'h0000;
    logic [23:0] exp_wr [$];
    logic [7:0]  exp_rx [$], rx_q [$], exp_host [$];
    logic [23:0] e_wr;
    logic [7:0]  got_rx;
    logic        hr_chk = 1'b0, watch = 1'b0, sda_low_seen = 1'b0, busy_seen = 1'b0;
    logic        collide_en = 1'b0;
    logic [7:0]  collide_a = 8'h00, collide_d = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (wr_strobe) begin
            if (exp_wr.size() == 0) begin
                total++;
                $display("FAIL unexpected_wr_strobe: got addr 0x%0h data 0x%0h, expected none", wr_addr, wr_data);
            end else begin
                e_wr = exp_wr.pop_front();
                check("wr_addr", {16'h0, wr_addr}, {16'h0, e_wr[23:8]});
                check("wr_data", {24'h0, wr_data}, {24'h0, e_wr[7:0]});
            end
        end
        if (rd_strobe) rd_cnt++;
        if (rx_q.size() > 0) begin
            got_rx = rx_q.pop_front();
            if (exp_rx.size() == 0) begin
                total++;
                $display("FAIL unexpected_rd_byte: got 0x%0h, expected none", got_rx);
            end else check("rd_byte", {24'h0, got_rx}, {24'h0, exp_rx.pop_front()});
        end
        if (hr_chk && exp_host.size() > 0)
            check("host_rd", {24'h0, host_rd_data}, {24'h0, exp_host.pop_front()});
        if (watch) begin
            if (!SDA_t) sda_low_seen = 1'b1;
            if (busy) busy_seen = 1'b1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; cyc(H); scl_m = 1'b1; cyc(H); sda_m = 1'b0; cyc(H); scl_m = 1'b0; cyc(H);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; cyc(H); scl_m = 1'b1; cyc(H); sda_m = 1'b1; cyc(H);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; cyc(H); scl_m = 1'b1;
            if (i == 0 && collide_en) begin
                cyc(2);
                host_addr = collide_a; host_wr_data = collide_d; host_wr_en = 1'b1;
                cyc(1);
                check("wr_strobe_latency", {31'h0, wr_strobe}, 32'h1);
                host_wr_en = 1'b0; collide_en = 1'b0;
                cyc(H - 3);
            end else cyc(H);
            scl_m = 1'b0; cyc(Q);
        end
        sda_m = 1'b1; cyc(H); scl_m = 1'b1; cyc(H / 2); ack = sda_line; cyc(H - H / 2); scl_m = 1'b0; cyc(Q);
    endtask

    task automatic send_chk(input logic [7:0] b, input logic exp_ack, input string name);
        logic a;
        send_byte(b, a);
        check(name, {31'h0, a}, {31'h0, exp_ack});
    endtask

    task automatic recv_byte(input logic nack);
        logic [7:0] b;
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            cyc(H); scl_m = 1'b1; cyc(H / 2); b[i] = sda_line; cyc(H - H / 2); scl_m = 1'b0; cyc(Q);
        end
        rx_q.push_back(b);
        sda_m = nack; cyc(H); scl_m = 1'b1; cyc(H); scl_m = 1'b0; cyc(Q); sda_m = 1'b1;
    endtask

    task automatic m_wr(input logic [7:0] b);
        exp_wr.push_back({ptr_m, b});
        mem_m[ptr_m[7:0]] = b;
        ptr_m = ptr_m + 16'd1;
    endtask

    task automatic m_rd;
        exp_rx.push_back(mem_m[ptr_m[7:0]]);
        ptr_m = ptr_m + 16'd1;
        exp_rd_cnt++;
    endtask

    task automatic wr_txn(input logic [15:0] p, input int n, input logic [31:0] data, input bit coll);
        logic [7:0] b;
        i2c_start;
        send_chk(8'h52, 1'b0, "ack_addr_w");
        check("busy_after_match", {31'h0, busy}, 32'h1);
        send_chk(p[15:8], 1'b0, "ack_ptrh");
        send_chk(p[7:0], 1'b0, "ack_ptrl");
        ptr_m = p;
        for (int i = 0; i < n; i++) begin
            b = data[8*i +: 8];
            if (i == 0 && coll) collide_en = 1'b1;
            m_wr(b);
            send_chk(b, 1'b0, "ack_wdata");
        end
        i2c_stop;
        check("busy_after_stop", {31'h0, busy}, 32'h0);
    endtask

    task automatic rd_txn(input bit set_ptr, input logic [15:0] p, input int n);
        if (set_ptr) begin
            i2c_start;
            send_chk(8'h52, 1'b0, "ack_addr_w");
            send_chk(p[15:8], 1'b0, "ack_ptrh");
            send_chk(p[7:0], 1'b0, "ack_ptrl");
            ptr_m = p;
        end
        i2c_start;
        send_chk(8'h53, 1'b0, "ack_addr_r");
        for (int i = 0; i < n; i++) begin
            m_rd;
            recv_byte(i == n - 1);
        end
        check("sda_released_after_nack", {31'h0, SDA_t}, 32'h1);
        i2c_stop;
    endtask

    task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
        host_addr = a; host_wr_data = d; host_wr_en = 1'b1; cyc(1); host_wr_en = 1'b0;
        mem_m[a] = d;
    endtask

    task automatic host_rd(input logic [7:0] a);
        host_addr = a; cyc(1);
        exp_host.push_back(mem_m[a]);
        hr_chk = 1'b1; cyc(1); hr_chk = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int base;
        reset = 1'b0;
        cyc(3);
        check("reset_sda_t", {31'h0, SDA_t}, 32'h1);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_wr_strobe", {31'h0, wr_strobe}, 32'h0);
        check("reset_rd_strobe", {31'h0, rd_strobe}, 32'h0);
        check("reset_wr_addr", {16'h0, wr_addr}, 32'h0);
        check("reset_wr_data", {24'h0, wr_data}, 32'h0);
        check("reset_host_rd", {24'h0, host_rd_data}, 32'h0);
        reset = 1'b1;
        cyc(3);

        for (int a = 0; a < 256; a++) host_wr(a[7:0], 8'($urandom));

        // Basic write, then confirm the pointer continued at 0x0102
        wr_txn(16'h0100, 2, 32'h0000CDAB, 1'b0);
        host_rd(8'h00);
        host_rd(8'h01);
        rd_txn(1'b0, 16'h0000, 1);

        // Combined write-pointer / repeated-START read
        host_wr(8'h10, 8'h5A);
        host_wr(8'h11, 8'hA5);
        cyc(2);
        base = rd_cnt;
        rd_txn(1'b1, 16'h0010, 2);
        cyc(2);
        check("rd_strobe_pair", rd_cnt - base, 32'd2);

        // Foreign address is ignored entirely
        sda_low_seen = 1'b0; busy_seen = 1'b0; watch = 1'b0;
        watch = 1'b1;
        i2c_start;
        send_chk(8'h60, 1'b1, "nack_mismatch");
        send_chk(8'($urandom), 1'b1, "nack_ignored_byte");
        send_chk(8'($urandom), 1'b1, "nack_ignored_byte");
        i2c_stop;
        watch = 1'b0;
        check("mismatch_sda_never_low", {31'h0, sda_low_seen}, 32'h0);
        check("mismatch_busy_never_high", {31'h0, busy_seen}, 32'h0);
        host_rd(ptr_m[7:0]);

        // Pointer wraps 0xFFFF -> 0x0000
        wr_txn(16'hFFFF, 2, 32'h00002211, 1'b0);
        host_rd(8'hFF);
        host_rd(8'h00);

        // Same-cycle host and I2C write to one address
        collide_a = 8'h34; collide_d = 8'hEE;
        wr_txn(16'h1234, 1, 32'h00000077, 1'b1);
        host_rd(8'h34);

        // Reset while the target drives a 0 read bit
        wr_txn(16'h0040, 1, 32'h0000003C, 1'b0);
        i2c_start;
        send_chk(8'h52, 1'b0, "ack_addr_w");
        send_chk(8'h00, 1'b0, "ack_ptrh");
        send_chk(8'h40, 1'b0, "ack_ptrl");
        i2c_start;
        send_chk(8'h53, 1'b0, "ack_addr_r");
        exp_rd_cnt++;
        for (int k = 0; k < 50 && SDA_t; k++) cyc(1);
        check("sda_low_before_reset", {31'h0, SDA_t}, 32'h0);
        reset = 1'b0;
        #1;
        check("async_reset_sda_t", {31'h0, SDA_t}, 32'h1);
        check("async_reset_busy", {31'h0, busy}, 32'h0);
        check("async_reset_wr_addr", {16'h0, wr_addr}, 32'h0);
        scl_m = 1'b1; sda_m = 1'b1;
        cyc(4);
        reset = 1'b1;
        ptr_m = 16'h0000;
        cyc(4);
        rd_txn(1'b0, 16'h0000, 1);

        // Randomized mix of writes, reads and host traffic
        for (int it = 0; it < 10; it++) begin
            case ($urandom_range(0, 2))
                0: wr_txn(16'($urandom), int'($urandom_range(1, 3)), $urandom, 1'b0);
                1: rd_txn(1'($urandom_range(0, 1)), 16'($urandom), int'($urandom_range(1, 3)));
                default: begin
                    host_wr(8'($urandom), 8'($urandom));
                    host_rd(8'($urandom));
                end
            endcase
        end

        cyc(10);
        check("rd_strobe_count", rd_cnt, exp_rd_cnt);
        check("wr_queue_drained", exp_wr.size(), 32'd0);
        check("rx_queue_drained", exp_rx.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/i2c_tof_target.md
# i2c_tof_target

I2C target (responder) that emulates a ToF sensor's register interface: it answers address 0x29, takes a 16-bit register pointer, and supports multi-byte writes and reads with auto-increment. It holds a small internal register memory that a host-side port can also access. It sits opposite the ToF I2C masters, either in loopback simulation or as an on-FPGA sensor stand-in, and connects through the same IOBUF convention (`*_t` = 1 releases the line).

## Interface
- SLAVE_ADDR, 7'h29, 7-bit target address
- MEM_AW, 8, memory address width; depth 2^MEM_AW bytes
- clk  in  1  system clock; must run at least 16× the SCL frequency
- reset  in  1  asynchronous, active-low
- SCL_in  in  1  SCL from IOBUF output
- SDA_in  in  1  SDA from IOBUF output
- SDA_t  out  1  1 = release SDA; 0 = drive low (IOBUF I tied 0)
- host_wr_en  in  1  host write strobe
- host_addr  in  MEM_AW  host address
- host_wr_data  in  8  host write data
- host_rd_data  out  8  mem[host_addr], registered, 1-cycle latency
- wr_strobe  out  1  1-cycle pulse for each byte written by the I2C master
- wr_addr  out  16  full pointer value of that write
- wr_data  out  8  byte written
- rd_strobe  out  1  1-cycle pulse when a read byte is loaded for transmit
- busy  out  1  high from an addressed match until STOP or the next START

## Operation
- SCL and SDA each pass through a 2-flop synchronizer, followed by a previous-value register used for edge detection.
- START: SDA falls while SCL is high. Valid from any state, including mid-byte; it clears the bit counter and enters ADDR (this also covers repeated START).
- STOP: SDA rises while SCL is high. Valid from any state; enters IDLE and releases SDA.
- Bits are sampled on the SCL rising edge, MSB first. An 8-bit shift register and a 3-bit counter track each byte.
- States and transitions:
  - IDLE: waits for START.
  - ADDR: after 8 bits, compares the address. On mismatch, go to IGNORE (SDA released until STOP/START). On match, drive ACK and remember the R/W bit.
  - ACK_A: if W, go to PTRH; if R, go to RDATA using the current pointer.
  - PTRH, then ACK: PTRL, then ACK: pointer = {hi, lo}. Then WDATA.
  - WDATA: after each byte, write mem[ptr[MEM_AW-1:0]], pulse wr_strobe with wr_addr=ptr, ACK, then ptr += 1.
  - RDATA: load mem[ptr[MEM_AW-1:0]], pulse rd_strobe, shift out 8 bits, then ptr += 1. Go to MACK.
  - MACK: release SDA and sample the master's ACK on SCL rise. ACK (0) returns to RDATA; NACK (1) goes to IGNORE.
- ACK drive: SDA_t goes to 0 on the SCL falling edge after the 8th bit and back to 1 on the next SCL falling edge. Read bits change only on SCL falling edges. Bit 7 of a read byte is driven on the falling edge that ends ACK_A or MACK.
- Pointer arithmetic is 16-bit and wraps from 0xFFFF to 0x0000. Memory uses the low MEM_AW bits, so higher pointer bits alias. The pointer persists across transactions and resets to 0.
- A write of only the pointer bytes followed by STOP changes the pointer and nothing else.
- Host port:
  - host_wr_en writes immediately.
  - If an I2C write and a host write target the same memory address in the same cycle, the I2C write wins and the host write is dropped.
  - Host reads are unaffected by I2C activity.
- Memory is not reset; contents are undefined until written.

## Timing
- Reset values: SDA_t=1, busy=0, wr_strobe=0, rd_strobe=0, wr_addr=0, wr_data=0, host_rd_data=0, pointer=0, state=IDLE, synchronizers=1.
- Reset asserted mid-transfer releases SDA asynchronously. After release, the block stays in IDLE until a fresh START.
- SDA_t changes 3 clk cycles after the pin-level SCL falling edge (2 synchronizer stages plus 1 register stage).
- wr_strobe asserts 3 clk cycles after the SCL rising edge of bit 0 (the 8th bit). wr_addr and wr_data are valid during that same cycle.
- rd_strobe fires in the same cycle that the byte is loaded into the transmit shifter.
- busy rises in the cycle the address matches. It falls in the cycle STOP or START is detected.

## Test plan
- Write: START, 0x52, 0x01, 0x00, 0xAB, 0xCD, STOP. Required: ACK on all 5 bytes; wr_strobe twice with (0x0100, 0xAB) then (0x0101, 0xCD); host read of 0x00 returns 0xAB and of 0x01 returns 0xCD; pointer ends at 0x0102.
- Combined read: host preloads mem[0x10]=0x5A and mem[0x11]=0xA5. START, 0x52, 0x00, 0x10, repeated START, 0x53, then read 2 bytes (ACK, then NACK), STOP. Required: master receives 0x5A then 0xA5; two rd_strobe pulses; SDA released after the NACK.
- Address mismatch: START, 0x60, … STOP. Required: NACK (SDA_t stays 1 throughout), busy stays 0, no strobes, memory unchanged.
- Pointer wrap: set pointer to 0xFFFF, write 0x11 and 0x22. Required: wr_addr is 0xFFFF then 0x0000; mem[0xFF]=0x11 and mem[0x00]=0x22.
- Reset mid-read: assert reset while SDA_t=0 during a read bit. Required: SDA_t=1 immediately; busy=0; pointer=0; next transaction behaves normally.
- Collision: host write and I2C write to the same address in the same cycle. Required: memory holds the I2C byte.
